// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU sequencer: one shared 1-bit slice, LSB first, WIDTH cycles per op.
// Optional SLT opcode (111) enabled by defining ALU_SEQ_SLT_EN.
module alu_serial_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_overflow,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

`ifdef ALU_SEQ_SLT_EN
    localparam logic SLT_EN = 1'b1;
`else
    localparam logic SLT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] acc_q;

    logic last;
    assign last = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic is_and;
    logic is_or;
    logic is_add;
    logic is_sub;
    logic is_slt;

    always_comb begin
        is_and = 1'b0;
        is_or  = 1'b0;
        is_add = 1'b0;
        is_sub = 1'b0;
        is_slt = 1'b0;
        case (op_q)
            OP_AND:  is_and = 1'b1;
            OP_OR:   is_or  = 1'b1;
            OP_ADD:  is_add = 1'b1;
            OP_SUB:  is_sub = 1'b1;
            OP_SLT: begin
                is_sub = SLT_EN;
                is_slt = SLT_EN;
            end
            default: ;
        endcase
    end

    logic a_bit;
    logic b_raw;
    logic b_bit;
    logic r_bit;
    logic cout;

    assign a_bit = a_q[cnt_q];
    assign b_raw = b_q[cnt_q];
    // Subtraction is a + ~b + 1: the +1 comes from the preset carry.
    assign b_bit = b_raw ^ is_sub;
    assign cout  = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));

    always_comb begin
        r_bit = 1'b0;
        unique case (1'b1)
            is_and:          r_bit = a_bit & b_bit;
            is_or:           r_bit = a_bit | b_bit;
            is_add | is_sub: r_bit = a_bit ^ b_bit ^ carry_q;
            default:         r_bit = 1'b0;
        endcase
    end

    logic [WIDTH-1:0] res_full;
    logic             ovf_add;
    logic             ovf_sub;
    logic [WIDTH-1:0] fin_res;
    logic             fin_ovf;
    logic             fin_cy;
    logic             fin_err;

    assign res_full = {r_bit, acc_q[WIDTH-1:1]};
    assign ovf_add  = (a_bit == b_raw) && (r_bit != a_bit);
    assign ovf_sub  = (a_bit != b_raw) && (r_bit != a_bit);

    always_comb begin
        fin_res = '0;
        fin_ovf = 1'b0;
        fin_cy  = 1'b0;
        fin_err = 1'b0;
        unique case (1'b1)
            is_slt: begin
                // Signed less-than: sign of the difference corrected by overflow.
                fin_res = {{(WIDTH-1){1'b0}}, r_bit ^ ovf_sub};
            end
            is_add: begin
                fin_res = res_full;
                fin_ovf = ovf_add;
                fin_cy  = cout;
            end
            is_sub: begin
                fin_res = res_full;
                fin_ovf = ovf_sub;
                fin_cy  = cout;
            end
            is_and | is_or: begin
                fin_res = res_full;
            end
            default: begin
                fin_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            cnt_q        <= '0;
            carry_q      <= 1'b0;
            acc_q        <= '0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_carry    <= 1'b0;
            out_zero     <= 1'b0;
            out_err      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        op_q    <= in_op;
                        cnt_q   <= '0;
                        carry_q <= (in_op == OP_SUB) || (in_op == OP_SLT);
                        acc_q   <= '0;
                    end
                end
                RUN: begin
                    acc_q   <= res_full;
                    carry_q <= cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last) begin
                        out_result   <= fin_res;
                        out_overflow <= fin_ovf;
                        out_carry    <= fin_cy;
                        out_zero     <= (fin_res == '0);
                        out_err      <= fin_err;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Scoreboard bench for alu_serial_sequencer at WIDTH=8.
// Build with ALU_SEQ_SLT_EN defined to exercise the SLT opcode.
module tb_alu_serial_sequencer;

    localparam int W = 8;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef struct packed {
        logic [W-1:0] r;
        logic         v;
        logic         c;
        logic         z;
        logic         e;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [2:0]   in_op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_result;
    logic         out_overflow;
    logic         out_carry;
    logic         out_zero;
    logic         out_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t sb[$];

    alu_serial_sequencer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_op        (in_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_carry    (out_carry),
        .out_zero     (out_zero),
        .out_err      (out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] op);
        exp_t e;
        logic [W:0] s;
        e = '0;
        s = '0;
        case (op)
            OP_AND: e.r = a & b;
            OP_OR:  e.r = a | b;
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                e.r = s[W-1:0];
                e.c = s[W];
                e.v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            OP_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 1;
                e.r = s[W-1:0];
                e.c = s[W];
                e.v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
            end
`ifdef ALU_SEQ_SLT_EN
            OP_SLT: e.r = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
`endif
            default: e.e = 1'b1;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input exp_t e, output int acc_cyc);
        int n;
        logic rdy;
        sb.push_back(e);
        in_a = a;
        in_b = b;
        in_op = op;
        in_valid = 1'b1;
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 40) begin
            rdy = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        acc_cyc = cyc;
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL send_accept: in_ready never high, got 0 want 1");
        end
    endtask

    task automatic collect(input string name, output int vcyc);
        int n;
        exp_t e;
        exp_t g;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        vcyc = cyc;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: out_valid=%b want 1 (timeout)", name, out_valid);
            return;
        end
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_sb: scoreboard empty, got output want none", name);
            return;
        end
        e = sb.pop_front();
        g = {out_result, out_overflow, out_carry, out_zero, out_err};
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got r=%h v=%b c=%b z=%b e=%b want r=%h v=%b c=%b z=%b e=%b",
                     name, g.r, g.v, g.c, g.z, g.e, e.r, e.v, e.c, e.z, e.e);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== e.r) begin
            errors++;
            $display("FAIL %s_after: out_valid=%b in_ready=%b r=%h want 0 1 %h",
                     name, out_valid, in_ready, out_result, e.r);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0 ||
            out_overflow !== 1'b0 || out_carry !== 1'b0 || out_zero !== 1'b0 ||
            out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b r=%h v=%b c=%b z=%b e=%b want 1 0 00 0 0 0 0",
                     in_ready, out_valid, out_result, out_overflow, out_carry,
                     out_zero, out_err);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_add_overflow();
        int ac;
        int vc;
        exp_t e;
        e = '{r: 8'h80, v: 1'b1, c: 1'b0, z: 1'b0, e: 1'b0};
        send(8'h7F, 8'h01, OP_ADD, e, ac);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL add_busy: in_ready=%b want 0", in_ready);
        end
        collect("add_7f_01", vc);
        checks++;
        if (vc - ac != W) begin
            errors++;
            $display("FAIL add_latency: got %0d want %0d", vc - ac, W);
        end
    endtask

    task automatic test_sub();
        int ac;
        int vc;
        exp_t e;
        e = '{r: 8'h7F, v: 1'b1, c: 1'b1, z: 1'b0, e: 1'b0};
        send(8'h80, 8'h01, OP_SUB, e, ac);
        collect("sub_80_01", vc);
        e = '{r: 8'h00, v: 1'b0, c: 1'b1, z: 1'b1, e: 1'b0};
        send(8'h05, 8'h05, OP_SUB, e, ac);
        collect("sub_05_05", vc);
        e = '{r: 8'h00, v: 1'b0, c: 1'b0, z: 1'b1, e: 1'b0};
        send(8'hFF, 8'h01, OP_ADD, e, ac);
        e.c = 1'b1;
        sb[sb.size()-1] = e;
        collect("add_ff_01", vc);
    endtask

    task automatic test_logic_random();
        int ac;
        int vc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0] op;
        logic [2:0] ops [5];
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT};
        send(8'hF0, 8'h3C, OP_AND, '{r: 8'h30, v: 0, c: 0, z: 0, e: 0}, ac);
        collect("and_f0_3c", vc);
        send(8'hA0, 8'h05, OP_OR, '{r: 8'hA5, v: 0, c: 0, z: 0, e: 0}, ac);
        collect("or_a0_05", vc);
        for (int i = 0; i < 12; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            op = ops[$urandom_range(0, 4)];
            send(a, b, op, model(a, b, op), ac);
            collect("random", vc);
        end
    endtask

    task automatic test_illegal();
        int ac;
        int vc;
        exp_t e;
        e = '{r: 8'h00, v: 1'b0, c: 1'b0, z: 1'b1, e: 1'b1};
        send(8'hAA, 8'h55, 3'b011, e, ac);
        collect("illegal_011", vc);
        checks++;
        if (vc - ac != W) begin
            errors++;
            $display("FAIL illegal_latency: got %0d want %0d", vc - ac, W);
        end
        send(8'hFF, 8'hFF, 3'b100, e, ac);
        collect("illegal_100", vc);
        send(8'h7F, 8'h01, 3'b101, e, ac);
        collect("illegal_101", vc);
    endtask

    task automatic test_slt();
        int ac;
        int vc;
        exp_t e;
`ifdef ALU_SEQ_SLT_EN
        e = '{r: 8'h01, v: 1'b0, c: 1'b0, z: 1'b0, e: 1'b0};
`else
        e = '{r: 8'h00, v: 1'b0, c: 1'b0, z: 1'b1, e: 1'b1};
`endif
        send(8'hFE, 8'h01, OP_SLT, e, ac);
        collect("slt_fe_01", vc);
    endtask

    task automatic test_backpressure();
        int ac;
        int vc;
        int n;
        exp_t e;
        exp_t g;
        exp_t snap;
        e = model(8'h3C, 8'h0F, OP_ADD);
        send(8'h3C, 8'h0F, OP_ADD, e, ac);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        sb.push_back(model(8'h11, 8'h22, OP_OR));
        in_a = 8'h11;
        in_b = 8'h22;
        in_op = OP_OR;
        in_valid = 1'b1;
        snap = {out_result, out_overflow, out_carry, out_zero, out_err};
        checks++;
        if (snap !== e) begin
            errors++;
            $display("FAIL bp_result: got r=%h want r=%h (vld=%b)", snap.r, e.r, out_valid);
        end
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            tick();
            g = {out_result, out_overflow, out_carry, out_zero, out_err};
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || g !== snap) begin
                errors++;
                $display("FAIL bp_hold%0d: vld=%b rdy=%b r=%h want 1 0 %h",
                         i, out_valid, in_ready, g.r, snap.r);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_idle: vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        ac = cyc;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept: in_ready=%b want 0", in_ready);
        end
        collect("bp_second", vc);
        checks++;
        if (vc - ac != W) begin
            errors++;
            $display("FAIL bp_latency: got %0d want %0d", vc - ac, W);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] av [4];
        logic [W-1:0] bv [4];
        logic [2:0]   ov [4];
        int idx;
        int got;
        int last_acc;
        int n;
        logic rdy;
        exp_t e;
        exp_t g;
        av = '{8'h40, 8'h80, 8'hC3, 8'h12};
        bv = '{8'h40, 8'h7F, 8'h3C, 8'h34};
        ov = '{OP_ADD, OP_SUB, OP_OR, OP_ADD};
        idx = 0;
        got = 0;
        last_acc = -1;
        n = 0;
        out_ready = 1'b1;
        sb.push_back(model(av[0], bv[0], ov[0]));
        in_a = av[0];
        in_b = bv[0];
        in_op = ov[0];
        in_valid = 1'b1;
        while (got < 4 && n < 200) begin
            rdy = in_ready;
            if (out_valid === 1'b1) begin
                e = sb.pop_front();
                g = {out_result, out_overflow, out_carry, out_zero, out_err};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL b2b_%0d: got r=%h v=%b c=%b want r=%h v=%b c=%b",
                             got, g.r, g.v, g.c, e.r, e.v, e.c);
                end
                got++;
            end
            tick();
            n++;
            if (rdy && in_valid) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != W + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d want %0d", cyc - last_acc, W + 2);
                    end
                end
                last_acc = cyc;
                idx++;
                if (idx < 4) begin
                    sb.push_back(model(av[idx], bv[idx], ov[idx]));
                    in_a = av[idx];
                    in_b = bv[idx];
                    in_op = ov[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 4", got);
        end
    endtask

    task automatic test_reset_midrun();
        int n;
        int ac;
        int vc;
        in_a = 8'hFF;
        in_b = 8'h01;
        in_op = OP_ADD;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0 ||
            out_overflow !== 1'b0 || out_carry !== 1'b0 || out_zero !== 1'b0 ||
            out_err !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: rdy=%b vld=%b r=%h v=%b c=%b z=%b e=%b want 1 0 00 0 0 0 0",
                     in_ready, out_valid, out_result, out_overflow, out_carry,
                     out_zero, out_err);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL midrun_stale: vld=%b sb=%0d want 0 0", out_valid, sb.size());
        end
        send(8'h01, 8'h01, OP_ADD, '{r: 8'h02, v: 0, c: 0, z: 0, e: 0}, ac);
        collect("midrun_fresh", vc);
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub();
        test_logic_random();
        test_illegal();
        test_slt();
        test_backpressure();
        test_back_to_back();
        test_reset_midrun();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d left want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
